// File: rtl/ddr_cmd_sequencer_pkg.sv
// Shared state encoding, burst/direction constants and preamble helper
// for the DDR command sequencer.
package ddr_cmd_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACT,
        PRE,
        BURST,
        DONE
    } seq_state_t;

    localparam logic [2:0] BL4_LAST = 3'd3;
    localparam logic [2:0] BL8_LAST = 3'd7;

    localparam logic [1:0] RW_IDLE = 2'b00;
    localparam logic [1:0] RW_WR   = 2'b01;
    localparam logic [1:0] RW_RD   = 2'b10;

    // Out-of-range preamble settings saturate into the supported 1..2 range.
    function automatic logic [1:0] pre_len(input logic [1:0] rd_pre);
        if (rd_pre == 2'd0)
            return 2'd1;
        else if (rd_pre == 2'd3)
            return 2'd2;
        else
            return rd_pre;
    endfunction

endpackage

// File: rtl/ddr_rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index at or after the
// rotating pointer, then moves the pointer just past the winner.
module ddr_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] req_valid,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx,
    output logic              grant_valid
);

    logic [CH_W-1:0] rr_ptr;

    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        if (enable) begin
            for (int off = 0; off < NUM_CH; off++) begin
                idx = (int'(rr_ptr) + off) % NUM_CH;
                if (!grant_valid && req_valid[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = CH_W'(idx);
                    grant[idx]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            rr_ptr <= '0;
        else if (grant_valid)
            rr_ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    end

endmodule

// File: rtl/ddr_cmd_sequencer.sv
// Arbitrates request channels into a FIFO and sequences each head request
// through activate, optional read preamble, burst beats and a settle cycle.
module ddr_cmd_sequencer
    import ddr_cmd_sequencer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH-1:0]        req_rw,
    input  logic [NUM_CH-1:0]        req_bl8,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_data,
    input  logic [1:0]               rd_pre,
    input  logic                     dev_busy,
    output logic                     act_cmd,
    output logic [ADDR_W-1:0]        cmd_addr,
    output logic [DATA_W-1:0]        cmd_data,
    output logic [CH_W-1:0]          cmd_ch,
    output logic [1:0]               dev_rw,
    output logic                     dev_rd,
    output logic                     next_cmd,
    output logic [2:0]               beat_cnt,
    output logic [CNT_W-1:0]         fifo_count
);

    // Entry layout depends on the width parameters, so it lives here rather than in the package.
    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic              rw;
        logic              bl8;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_entry_t;

    req_entry_t       fifo_mem [DEPTH];
    req_entry_t       push_entry;
    req_entry_t       cmd_q;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [CH_W-1:0]  grant_idx;
    seq_state_t       state;
    seq_state_t       next_state;
    logic [1:0]       pre_len_q;
    logic [1:0]       pre_cnt;
    logic [2:0]       beat_q;
    logic             last_beat;

    assign full  = (fifo_count == CNT_W'(DEPTH));
    assign empty = (fifo_count == '0);
    assign pop   = (state == IDLE) && !empty && !dev_busy;

    ddr_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arbiter (
        .clock       (clock),
        .reset       (reset),
        .enable      (!full && !reset),
        .req_valid   (req_valid),
        .grant       (req_ready),
        .grant_idx   (grant_idx),
        .grant_valid (push)
    );

    always_comb begin
        push_entry      = '0;
        push_entry.ch   = grant_idx;
        push_entry.rw   = req_rw[grant_idx];
        push_entry.bl8  = req_bl8[grant_idx];
        push_entry.addr = req_addr[grant_idx*ADDR_W +: ADDR_W];
        push_entry.data = req_data[grant_idx*DATA_W +: DATA_W];
    end

    // Storage is not reset; clearing the pointers and count is what drops stale entries.
    always_ff @(posedge clock) begin
        if (push)
            fifo_mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                fifo_count <= fifo_count + CNT_W'(1);
            else if (pop && !push)
                fifo_count <= fifo_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Request fields and preamble length are frozen at pop so they hold steady through DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd_q     <= '0;
            pre_len_q <= 2'd1;
            pre_cnt   <= 2'd0;
            beat_q    <= 3'd0;
        end else begin
            if (pop) begin
                cmd_q     <= fifo_mem[rd_ptr];
                pre_len_q <= pre_len(rd_pre);
            end
            case (state)
                ACT:     pre_cnt <= 2'd0;
                PRE:     pre_cnt <= pre_cnt + 2'd1;
                BURST:   if (!last_beat) beat_q <= beat_q + 3'd1;
                DONE:    beat_q <= 3'd0;
                default: ;
            endcase
        end
    end

    assign last_beat = (beat_q == (cmd_q.bl8 ? BL8_LAST : BL4_LAST));

    always_comb begin
        next_state = state;
        act_cmd    = 1'b0;
        dev_rw     = RW_IDLE;
        dev_rd     = 1'b0;
        next_cmd   = 1'b0;
        case (state)
            IDLE:  if (pop) next_state = ACT;
            ACT: begin
                act_cmd    = 1'b1;
                next_state = cmd_q.rw ? PRE : BURST;
            end
            PRE: begin
                dev_rd = 1'b1;
                if (pre_cnt == pre_len_q - 2'd1)
                    next_state = BURST;
            end
            BURST: begin
                dev_rw   = cmd_q.rw ? RW_RD : RW_WR;
                dev_rd   = cmd_q.rw;
                next_cmd = last_beat;
                if (last_beat)
                    next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign cmd_addr = cmd_q.addr;
    assign cmd_data = cmd_q.data;
    assign cmd_ch   = cmd_q.ch;
    assign beat_cnt = beat_q;

endmodule
